// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // Operation context captured at accept and held for the whole iteration.
    typedef struct packed {
        muldiv_op_t op;
        logic       word;
        logic       neg;
    } ctx_t;

    function automatic bit steps_legal(input int steps);
        return (steps == 1) || (steps == 2) || (steps == 4);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational datapath: STEPS shift-add multiply or restoring-divide steps on {acc, opnd}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int STEPS = 1
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] addend,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] opnd_next
);
    logic [XLEN-1:0] acc_v;
    logic [XLEN-1:0] opnd_v;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   trial;

    // NOTE: blocking assignments are intentional here; each unrolled step consumes the
    // previous step's value within the same evaluation, and every variable gets a default
    // first so no latch is inferred.
    always_comb begin
        acc_v  = acc;
        opnd_v = opnd;
        sum    = '0;
        trial  = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (is_div) begin
                // Shift the next dividend bit into the partial remainder, subtract if it fits.
                trial  = {acc_v, opnd_v[XLEN-1]};
                opnd_v = {opnd_v[XLEN-2:0], 1'b0};
                if (trial >= {1'b0, addend}) begin
                    trial     = trial - {1'b0, addend};
                    opnd_v[0] = 1'b1;
                end
                acc_v = trial[XLEN-1:0];
            end else begin
                // {acc, opnd} is the running product; the multiplier drains out of opnd[0].
                sum    = {1'b0, acc_v} + (opnd_v[0] ? {1'b0, addend} : '0);
                opnd_v = {sum[0], opnd_v[XLEN-1:1]};
                acc_v  = sum[XLEN:1];
            end
        end
        acc_next  = acc_v;
        opnd_next = opnd_v;
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV64M multiply/divide unit: one op per valid/ready handshake, STEPS bits per cycle,
// result held until consumed, abandonable by flush.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int STEPS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_t      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int N_FULL = XLEN / STEPS;
    localparam int N_WORD = 32 / STEPS;
    localparam int CNT_W  = $clog2(N_FULL + 1);

    if (!steps_legal(STEPS) || (XLEN % (2 * STEPS)) != 0) begin : g_param_check
        $error("muldiv_iter: STEPS must be 1, 2 or 4 and divide XLEN/2");
    end

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    state_t           state;
    ctx_t             ctx;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  opnd;
    logic [XLEN-1:0]  addend;

    // Operand preparation on the raw request.
    logic            a_sgn, b_sgn, a_neg, b_neg, is_div;
    logic            b_zero, ovf, special, neg_fix;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg, special_res;

    always_comb begin
        a_sgn  = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn  = op inside {OP_MULH, OP_DIV, OP_REM};
        is_div = op_is_div(op);
        if (word) begin
            a_ext   = {{(XLEN-32){a_sgn & a[31]}}, a[31:0]};
            b_ext   = {{(XLEN-32){b_sgn & b[31]}}, b[31:0]};
            min_neg = {{(XLEN-31){1'b1}}, {31{1'b0}}};
        end else begin
            a_ext   = a;
            b_ext   = b;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg   = a_sgn & a_ext[XLEN-1];
        b_neg   = b_sgn & b_ext[XLEN-1];
        a_abs   = a_neg ? -a_ext : a_ext;
        b_abs   = b_neg ? -b_ext : b_ext;
        // Remainder follows the dividend's sign; product and quotient follow the XOR.
        neg_fix = op_is_rem(op) ? a_neg : (a_neg ^ b_neg);

        b_zero  = (b_ext == '0);
        ovf     = b_sgn && is_div && (a_ext == min_neg) && (b_ext == '1);
        special = is_div && (b_zero || ovf);
        if (op_is_rem(op)) begin
            special_res = b_zero ? a_ext : '0;
        end else begin
            special_res = b_zero ? '1 : a_ext;
        end
        if (word) begin
            special_res = sext_w(special_res);
        end
    end

    logic [XLEN-1:0] acc_nx, opnd_nx;

    muldiv_step #(
        .XLEN  (XLEN),
        .STEPS (STEPS)
    ) u_step (
        .is_div    (op_is_div(ctx.op)),
        .acc       (acc),
        .opnd      (opnd),
        .addend    (addend),
        .acc_next  (acc_nx),
        .opnd_next (opnd_nx)
    );

    // Sign fix and result select on the value the final step produces.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_fix, rem_fix, sel, final_res;

    always_comb begin
        prod = {acc_nx, opnd_nx};
        // A W multiply ran only 32 steps, leaving the product 32 bits too high.
        if (ctx.word) begin
            prod = prod >> 32;
        end
        if (ctx.neg) begin
            prod = -prod;
        end
        quo_fix = ctx.neg ? -opnd_nx : opnd_nx;
        rem_fix = ctx.neg ? -acc_nx : acc_nx;
        case (ctx.op)
            OP_MUL:                       sel = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sel = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              sel = quo_fix;
            default:                      sel = rem_fix;
        endcase
        final_res = ctx.word ? sext_w(sel) : sel;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ctx       <= '0;
            count     <= '0;
            acc       <= '0;
            opnd      <= '0;
            addend    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        in_ready <= 1'b0;
                        ctx      <= '{op: op, word: word, neg: neg_fix};
                        acc      <= '0;
                        opnd     <= is_div ? (word ? (a_abs << 32) : a_abs) : b_abs;
                        addend   <= is_div ? b_abs : a_abs;
                        count    <= word ? CNT_W'(N_WORD) : CNT_W'(N_FULL);
                        if (special) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= special_res;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        acc   <= acc_nx;
                        opnd  <= opnd_nx;
                        count <= count - 1'b1;
                        if (count == CNT_W'(1)) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= final_res;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: three instances (STEPS 1/2/4) against an arithmetic reference model.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int XLEN = 64;
    localparam int NI   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            flush;
    logic            out_ready;
    logic            word;
    muldiv_op_t      op;
    logic [63:0]     a;
    logic [63:0]     b;
    logic [NI-1:0]   in_ready;
    logic [NI-1:0]   out_valid;
    logic [63:0]     result [NI];

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: spec-level state plus the value the current op must return.
    int          m_state [NI];
    int          m_cnt   [NI];
    logic [63:0] m_res   [NI];
    logic [63:0] m_pend  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        muldiv_iter #(
            .XLEN  (XLEN),
            .STEPS (1 << g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .op        (op),
            .word      (word),
            .a         (a),
            .b         (b),
            .flush     (flush),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .result    (result[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_result(input muldiv_op_t o, input logic w,
                                                 input logic [63:0] x, input logic [63:0] y);
        logic [127:0]       p;
        logic [31:0]        r32;
        logic [63:0]        r;
        logic signed [31:0] sx, sy;
        p   = '0;
        r   = '0;
        r32 = '0;
        sx  = x[31:0];
        sy  = y[31:0];
        if (w) begin
            case (o)
                OP_DIV: begin
                    if (y[31:0] == 0) r32 = '1;
                    else if (x[31:0] == 32'h8000_0000 && y[31:0] == '1) r32 = x[31:0];
                    else r32 = sx / sy;
                end
                OP_DIVU: begin
                    if (y[31:0] == 0) r32 = '1;
                    else r32 = x[31:0] / y[31:0];
                end
                OP_REM: begin
                    if (y[31:0] == 0) r32 = x[31:0];
                    else if (x[31:0] == 32'h8000_0000 && y[31:0] == '1) r32 = '0;
                    else r32 = sx % sy;
                end
                OP_REMU: begin
                    if (y[31:0] == 0) r32 = x[31:0];
                    else r32 = x[31:0] % y[31:0];
                end
                default: r32 = x[31:0] * y[31:0];
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (o)
                OP_MUL:    r = x * y;
                OP_MULH:   begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; r = p[127:64]; end
                OP_MULHSU: begin p = {{64{x[63]}}, x} * {64'd0, y};       r = p[127:64]; end
                OP_MULHU:  begin p = {64'd0, x} * {64'd0, y};             r = p[127:64]; end
                OP_DIV: begin
                    if (y == 0) r = '1;
                    else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x;
                    else r = $signed(x) / $signed(y);
                end
                OP_DIVU: begin
                    if (y == 0) r = '1;
                    else r = x / y;
                end
                OP_REM: begin
                    if (y == 0) r = x;
                    else if (x == 64'h8000_0000_0000_0000 && y == '1) r = '0;
                    else r = $signed(x) % $signed(y);
                end
                default: begin
                    if (y == 0) r = x;
                    else r = x % y;
                end
            endcase
        end
        return r;
    endfunction

    function automatic bit model_special(input muldiv_op_t o, input logic w,
                                         input logic [63:0] x, input logic [63:0] y);
        bit zero, ovf;
        if (!op_is_div(o)) return 1'b0;
        zero = w ? (y[31:0] == 0) : (y == 0);
        ovf  = (o == OP_DIV || o == OP_REM) &&
               (w ? (x[31:0] == 32'h8000_0000 && y[31:0] == '1)
                  : (x == 64'h8000_0000_0000_0000 && y == '1));
        return zero || ovf;
    endfunction

    task automatic model_step(input int i);
        if (reset) begin
            m_state[i] = 0;
            m_cnt[i]   = 0;
            m_res[i]   = '0;
        end else begin
            case (m_state[i])
                0: if (in_valid && !flush) begin
                    m_pend[i] = model_result(op, word, a, b);
                    if (model_special(op, word, a, b)) begin
                        m_state[i] = 2;
                        m_res[i]   = m_pend[i];
                    end else begin
                        m_state[i] = 1;
                        m_cnt[i]   = (word ? 32 : 64) >> i;
                    end
                end
                1: if (flush) begin
                    m_state[i] = 0;
                end else begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_state[i] = 2;
                        m_res[i]   = m_pend[i];
                    end
                end
                default: if (flush || out_ready) m_state[i] = 0;
            endcase
        end
    endtask

    // Advance one clock: model sees the edge, then all outputs are compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(m_state[i] == 0));
            check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(m_state[i] == 2));
            if (m_state[i] == 2) check($sformatf("result[%0d]", i), result[i], m_res[i]);
        end
    endtask

    task automatic run_op(input muldiv_op_t o, input logic w, input logic [63:0] ai,
                          input logic [63:0] bi, input logic [63:0] ev, input int hold);
        int lat [NI];
        bit all_seen;
        int want;
        check($sformatf("model %s w=%0d", o.name(), w), model_result(o, w, ai, bi), ev);
        op       = o;
        word     = w;
        a        = ai;
        b        = bi;
        in_valid = 1'b1;
        for (int i = 0; i < NI; i++) lat[i] = 0;
        tick();
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        for (int cyc = 1; cyc <= 200; cyc++) begin
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (out_valid[i] && lat[i] == 0) begin
                    lat[i] = cyc;
                    check($sformatf("%s w=%0d steps=%0d value", o.name(), w, 1 << i), result[i], ev);
                end
                if (lat[i] == 0) all_seen = 1'b0;
            end
            if (all_seen) break;
            tick();
        end
        for (int i = 0; i < NI; i++) begin
            want = model_special(o, w, ai, bi) ? 1 : ((w ? 32 : 64) >> i) + 1;
            check($sformatf("%s w=%0d steps=%0d latency", o.name(), w, 1 << i), 64'(lat[i]), 64'(want));
        end
        // Requests while the unit holds a result must be ignored.
        if (hold > 0) begin
            op       = OP_DIVU;
            in_valid = 1'b1;
            repeat (hold) tick();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin : stim
        bit seen;
        for (int i = 0; i < NI; i++) begin
            m_state[i] = 0;
            m_cnt[i]   = 0;
            m_res[i]   = '0;
            m_pend[i]  = '0;
        end
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        word      = 1'b0;
        op        = OP_MUL;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset in_ready[%0d]", i), 64'(in_ready[i]), 64'd1);
            check($sformatf("reset out_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
            check($sformatf("reset result[%0d]", i), result[i], 64'd0);
        end
        reset = 1'b0;
        tick();

        run_op(OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op(OP_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op(OP_MULH,   1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 0);
        run_op(OP_MULH,   1'b0, '1, '1, 64'd0, 0);
        run_op(OP_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(OP_DIV,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(OP_REM,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0);
        run_op(OP_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 0);
        run_op(OP_REMU,   1'b0, 64'd100, 64'd7, 64'd2, 0);
        run_op(OP_DIV,    1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(OP_REM,    1'b0, 64'd5, 64'd0, 64'd5, 0);
        run_op(OP_DIV,    1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0);
        run_op(OP_REM,    1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 0);
        run_op(OP_DIVU,   1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 0);
        run_op(OP_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op(OP_DIV,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(OP_REM,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(OP_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 0);
        run_op(OP_REMU,   1'b1, 64'hABCD_0000_9000_0001, 64'hFFFF_FFFF_0000_0000,
               64'hFFFF_FFFF_9000_0001, 0);

        // Result held for 10 cycles, then back-to-back accept right after release.
        run_op(OP_MULHU,  1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0121_FA00_AD77_D742, 10);
        run_op(OP_DIVU,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 0);

        // Flush during iteration: no result may ever appear for that op.
        op       = OP_DIV;
        word     = 1'b0;
        a        = 64'd1000;
        b        = 64'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (19) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen  = 1'b0;
        repeat (80) begin
            tick();
            seen |= |out_valid;
        end
        check("flush suppresses out_valid", 64'(seen), 64'd0);

        // Flush in IDLE blocks a simultaneous request.
        op       = OP_MUL;
        a        = 64'd3;
        b        = 64'd4;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        seen     = 1'b0;
        repeat (3) begin
            tick();
            seen |= |out_valid;
        end
        check("idle flush blocks accept", 64'(seen), 64'd0);
        run_op(OP_MUL, 1'b0, 64'd3, 64'd4, 64'd12, 0);

        // Asynchronous reset mid-iteration.
        op       = OP_MUL;
        a        = '1;
        b        = 64'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async reset in_ready[%0d]", i), 64'(in_ready[i]), 64'd1);
            check($sformatf("async reset out_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
            check($sformatf("async reset result[%0d]", i), result[i], 64'd0);
        end
        tick();
        reset = 1'b0;
        tick();
        run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
